// File: rtl/auto_updn_pkg.sv
// Shared types and constants for the auto-direction sweep counter.
package auto_updn_pkg;

    // Sweep FSM state encoding
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } state_t;

    // Run mode selection
    localparam logic MODE_CONT   = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;

endpackage

// File: rtl/updn_sat_step.sv
// Combinational step of the sweep counter: add or subtract the step and clamp
// the result to the active limit, computed one bit wider so it never wraps.
module updn_sat_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] limit,
    input  logic             up,
    output logic [WIDTH-1:0] count_next
);

    // Upward step, clamped to the upper limit
    function automatic logic [WIDTH-1:0] sat_add(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] s,
        input logic [WIDTH-1:0] lim
    );
        logic [WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, s};
        return (sum >= {1'b0, lim}) ? lim : sum[WIDTH-1:0];
    endfunction

    // Downward step, clamped to the lower limit; a borrow also clamps
    function automatic logic [WIDTH-1:0] sat_sub(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] s,
        input logic [WIDTH-1:0] lim
    );
        logic [WIDTH:0] diff;
        diff = {1'b0, a} - {1'b0, s};
        return (diff[WIDTH] || (diff[WIDTH-1:0] <= lim)) ? lim : diff[WIDTH-1:0];
    endfunction

    assign count_next = up ? sat_add(count, step, limit) : sat_sub(count, step, limit);

endmodule

// File: rtl/auto_updn_sweep_ctr.sv
// Triangular sweep counter: ramps Count between Lo_Lim and Hi_Lim in steps of
// STEP, either ping-ponging forever or doing one up/down sweep ending in Done.
module auto_updn_sweep_ctr
    import auto_updn_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Activate,
    input  logic             Halt,
    input  logic             Mode,
    input  logic [WIDTH-1:0] Lo_Lim,
    input  logic [WIDTH-1:0] Hi_Lim,
    output logic [WIDTH-1:0] Count,
    output logic             UP_M,
    output logic             DN_M,
    output logic             At_Hi,
    output logic             At_Lo,
    output logic             Done,
    output logic             Err
);

    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] step_lim;
    logic             step_up;
    logic             done_next;
    logic             err_next;

    // Single shared stepper; the FSM picks direction and clamp limit
    updn_sat_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .count      (Count),
        .step       (STEP_V),
        .limit      (step_lim),
        .up         (step_up),
        .count_next (stepped)
    );

    // Limit flags follow the registered count against the live limits
    assign At_Hi = (Count == Hi_Lim);
    assign At_Lo = (Count == Lo_Lim);

    // Next-state, next-count and pulse decode; Halt outranks the FSM
    always_comb begin
        state_next = state;
        count_next = Count;
        done_next  = 1'b0;
        err_next   = 1'b0;
        step_up    = 1'b1;
        step_lim   = Hi_Lim;
        if (Halt) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (Activate) begin
                        if (Lo_Lim < Hi_Lim) begin
                            state_next = (Count < Hi_Lim) ? UP : DOWN;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                end
                UP: begin
                    step_up  = 1'b1;
                    step_lim = Hi_Lim;
                    // >= so a count left above a lowered limit turns around
                    if (Count >= Hi_Lim) begin
                        state_next = DOWN;
                    end else begin
                        count_next = stepped;
                    end
                end
                DOWN: begin
                    step_up  = 1'b0;
                    step_lim = Lo_Lim;
                    if (Count <= Lo_Lim) begin
                        if (Mode == MODE_SINGLE) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = UP;
                        end
                    end else begin
                        count_next = stepped;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State, count and registered outputs; direction flags decode next state
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            Count <= '0;
            UP_M  <= 1'b0;
            DN_M  <= 1'b0;
            Done  <= 1'b0;
            Err   <= 1'b0;
        end else begin
            state <= state_next;
            Count <= count_next;
            UP_M  <= (state_next == UP);
            DN_M  <= (state_next == DOWN);
            Done  <= done_next;
            Err   <= err_next;
        end
    end

endmodule
